// File: rtl/jam_perm_if.sv
// Permutation stream handshake between the sequencer and the cost datapath.
// Carries the valid/ready pair, the packed worker-to-job map and the last flag.
interface jam_perm_if #(
  parameter int N  = 8,
  parameter int IW = 3
);
  logic          perm_valid;
  logic          perm_ready;
  logic [N*IW-1:0] perm;
  logic          perm_last;

  modport master (
    output perm_valid,
    output perm,
    output perm_last,
    input  perm_ready
  );

  modport slave (
    input  perm_valid,
    input  perm,
    input  perm_last,
    output perm_ready
  );
endinterface

// File: rtl/jam_perm_sched.sv
// Lexicographic permutation sequencer for the exhaustive job-assignment search.
// Optional ordinal output perm_idx is enabled by defining JAM_PERM_IDX_EN.
module jam_perm_sched #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  jam_perm_if.master  pif,
  output logic        busy,
  output logic        done
`ifdef JAM_PERM_IDX_EN
  ,
  output logic [15:0] perm_idx
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    EMIT,
    PIVOT,
    SUCC,
    SWAP,
    REV,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   slot_q [N];
  logic [IW-1:0]   slot_d [N];
  logic [IW-1:0]   rev    [N];
  logic [IW-1:0]   p_q, p_d;
  logic [IW-1:0]   s_q, s_d;
  logic [IW-1:0]   q_q, q_d;
  logic [IW-1:0]   piv;
  logic            desc;

`ifdef JAM_PERM_IDX_EN
  logic [15:0]     idx_q, idx_d;
`endif

  always_comb begin
    desc = 1'b1;
    piv  = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (slot_q[i] <= slot_q[i+1])
        desc = 1'b0;
      if (slot_q[i] < slot_q[i+1])
        piv = IW'(i);
    end
  end

  // Suffix p+1..N-1 mirrored in place; slots up to p pass through.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rev[i] = slot_q[i];
      if (i > int'(p_q))
        rev[i] = slot_q[IW'(N + int'(p_q) - i)];
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    p_d     = p_q;
    s_d     = s_q;
    q_d     = q_q;
`ifdef JAM_PERM_IDX_EN
    idx_d   = idx_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < N; i++)
            slot_d[i] = IW'(i);
`ifdef JAM_PERM_IDX_EN
          idx_d   = '0;
`endif
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (pif.perm_ready) begin
          if (desc) begin
            state_d = DONE;
          end else begin
            state_d = PIVOT;
`ifdef JAM_PERM_IDX_EN
            idx_d   = idx_q + 16'd1;
`endif
          end
        end
      end
      PIVOT: begin
        p_d     = piv;
        s_d     = IW'(N - 1);
        state_d = SUCC;
      end
      SUCC: begin
        if (slot_q[s_q] > slot_q[p_q]) begin
          q_d     = s_q;
          state_d = SWAP;
        end else begin
          s_d = s_q - 1'b1;
        end
      end
      SWAP: begin
        slot_d[p_q] = slot_q[q_q];
        slot_d[q_q] = slot_q[p_q];
        state_d     = REV;
      end
      REV: begin
        slot_d  = rev;
        state_d = EMIT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      for (int i = 0; i < N; i++)
        slot_q[i] <= IW'(i);
      p_q <= '0;
      s_q <= '0;
      q_q <= '0;
`ifdef JAM_PERM_IDX_EN
      idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      p_q     <= p_d;
      s_q     <= s_d;
      q_q     <= q_d;
`ifdef JAM_PERM_IDX_EN
      idx_q   <= idx_d;
`endif
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++)
      pif.perm[k*IW +: IW] = slot_q[k];
  end

  assign pif.perm_valid = (state_q == EMIT);
  assign pif.perm_last  = (state_q == EMIT) && desc;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);

`ifdef JAM_PERM_IDX_EN
  assign perm_idx = idx_q;
`endif

endmodule
